// File: rtl/step_ctrl_pkg.sv
// Shared definitions for the step controller: FSM state encodings and
// the default debounce length and cycle-counter width.
package step_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_PAUSE  = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   // 10 ms at 100 MHz
   localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;
   localparam int unsigned CNT_W_DEF           = 32;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, consecutive-cycle debounce
// counter, debounced level and a single-cycle rising-edge pulse.
// Ports:
//   clk_i   system clock
//   rst_i   asynchronous active-high reset
//   btn_i   raw bouncing button, asynchronous to clk_i
//   rise_o  one-cycle pulse, registered, when the debounced level goes 0->1
module btn_debounce
   import step_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic rise_o
);

   localparam int unsigned DBW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
   // Count value reached on the last of DEBOUNCE_CYCLES differing samples.
   localparam logic [DBW-1:0] CNT_TC = DBW'(DEBOUNCE_CYCLES - 1);

   logic           sync1_q;
   logic           sync2_q;
   logic           level_q;
   logic           rise_q;
   logic [DBW-1:0] cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         rise_q  <= 1'b0;
         if (sync2_q != level_q) begin
            if (cnt_q == CNT_TC) begin
               level_q <= sync2_q;
               cnt_q   <= '0;
               rise_q  <= sync2_q;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end else begin
            // any reversion to the current level restarts the run
            cnt_q <= '0;
         end
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/step_ctrl.sv
// CPU clock-step controller. Issues single-cycle cpu_en pulses either on
// each rising edge of the slow tick (free-run) or on each debounced button
// press (manual step); a CPU halt request latches until reset.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_PAUSE  | manual mode, step requests issue cpu_en
// ST_RUN    | free-run, tick events issue cpu_en
// ST_HALTED | CPU halted, nothing issued until rst
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   tick_in    slow divided clock, asynchronous, treated as data
//   btn_step   raw manual step button, asynchronous
//   sw_auto    raw mode switch, asynchronous (1 = free-run)
//   halt       synchronous halt request level from the CPU
//   cpu_en     one-cycle CPU advance enable
//   running    high in ST_RUN
//   halted     high in ST_HALTED
//   cycle_cnt  number of cpu_en pulses since reset, wrapping
module step_ctrl
   import step_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned CNT_W           = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick_in,
   input  logic             btn_step,
   input  logic             sw_auto,
   input  logic             halt,
   output logic             cpu_en,
   output logic             running,
   output logic             halted,
   output logic [CNT_W-1:0] cycle_cnt
);

   logic             tick_s1_q;
   logic             tick_s2_q;
   logic             tick_prev_q;
   logic [1:0]       tick_vld_q;
   logic             tick_armed_q;
   logic             tick_evt_q;
   logic             sw_s1_q;
   logic             sw_s2_q;
   logic             step_req;

   state_t           state_q;
   state_t           state_d;
   logic             cpu_en_q;
   logic             cpu_en_d;
   logic             running_q;
   logic             halted_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Tick front end. tick_vld_q marks when tick_s2_q holds a real sample
   // rather than its reset value; a tick is only armed after a genuine low
   // has been seen, so a tick_in already high at reset release is ignored
   // until its next rising edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_s1_q    <= 1'b0;
         tick_s2_q    <= 1'b0;
         tick_prev_q  <= 1'b0;
         tick_vld_q   <= 2'b00;
         tick_armed_q <= 1'b0;
         tick_evt_q   <= 1'b0;
         sw_s1_q      <= 1'b0;
         sw_s2_q      <= 1'b0;
      end else begin
         tick_s1_q    <= tick_in;
         tick_s2_q    <= tick_s1_q;
         tick_prev_q  <= tick_s2_q;
         tick_vld_q   <= {tick_vld_q[0], 1'b1};
         tick_armed_q <= tick_armed_q | (tick_vld_q[1] & ~tick_s2_q);
         tick_evt_q   <= tick_s2_q & ~tick_prev_q & tick_armed_q;
         sw_s1_q      <= sw_auto;
         sw_s2_q      <= sw_s1_q;
      end
   end

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn_debounce (
      .clk_i  (clk),
      .rst_i  (rst),
      .btn_i  (btn_step),
      .rise_o (step_req)
   );

   // Priority: halt, then mode change, then the advance request.
   // The ~cpu_en_q term guarantees a gap between pulses.
   always_comb begin
      state_d  = state_q;
      cpu_en_d = 1'b0;
      case (state_q)
         ST_PAUSE: begin
            if (halt)         state_d = ST_HALTED;
            else if (sw_s2_q) state_d = ST_RUN;
            else if (step_req) cpu_en_d = ~cpu_en_q;
         end
         ST_RUN: begin
            if (halt)            state_d = ST_HALTED;
            else if (!sw_s2_q)   state_d = ST_PAUSE;
            else if (tick_evt_q) cpu_en_d = ~cpu_en_q;
         end
         ST_HALTED: state_d = ST_HALTED;
         default:   state_d = ST_PAUSE;
      endcase
      cnt_d = cnt_q + CNT_W'(cpu_en_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_PAUSE;
         cpu_en_q  <= 1'b0;
         running_q <= 1'b0;
         halted_q  <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         cpu_en_q  <= cpu_en_d;
         running_q <= (state_d == ST_RUN);
         halted_q  <= (state_d == ST_HALTED);
         cnt_q     <= cnt_d;
      end
   end

   assign cpu_en    = cpu_en_q;
   assign running   = running_q;
   assign halted    = halted_q;
   assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_step_ctrl.sv
module tb_step_ctrl;

   localparam int DB = 4;
   localparam int CW = 4;

   localparam int M_PAUSE = 0;
   localparam int M_RUN   = 1;
   localparam int M_HALT  = 2;

   logic          clk;
   logic          rst;
   logic          tick_in;
   logic          btn_step;
   logic          sw_auto;
   logic          halt;
   logic          cpu_en;
   logic          running;
   logic          halted;
   logic [CW-1:0] cycle_cnt;

   step_ctrl #(
      .DEBOUNCE_CYCLES(DB),
      .CNT_W          (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .tick_in   (tick_in),
      .btn_step  (btn_step),
      .sw_auto   (sw_auto),
      .halt      (halt),
      .cpu_en    (cpu_en),
      .running   (running),
      .halted    (halted),
      .cycle_cnt (cycle_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      int cnt;
   } exp_t;

   exp_t q[$];
   int   checks;
   int   errors;
   int   cyc;
   int   m_state;
   int   m_cnt;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      cycles(3);
      rst = 1'b0;
   endtask

   // tick_in high for hi cycles then low for lo cycles
   task automatic tick_period(input int hi, input int lo);
      tick_in = 1'b1;
      cycles(hi);
      tick_in = 1'b0;
      cycles(lo);
   endtask

   task automatic rand_run(input int n);
      int tick_left;
      tick_left = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 5) == 0) btn_step = ~btn_step;
         if ($urandom_range(0, 49) == 0) sw_auto = ~sw_auto;
         tick_left--;
         if (tick_left == 0) begin
            tick_in   = ~tick_in;
            tick_left = $urandom_range(1, 6);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      rst      = 1'b1;
      tick_in  = 1'b0;
      btn_step = 1'b0;
      sw_auto  = 1'b0;
      halt     = 1'b0;
      checks   = 0;
      errors   = 0;
      cyc      = 0;
      m_state  = M_PAUSE;
      m_cnt    = 0;

      fork
         // Reference model: pulse predictions from raw input history.
         begin : model
            bit th[0:4];
            bit sh[0:2];
            bit bh[0:2];
            int nsamp;
            bit lvl;
            int run;
            bit step_p;
            bit tick_ev;
            bit step;
            bit en;
            forever begin
               @(posedge clk or posedge rst);
               if (rst) begin
                  for (int i = 0; i < 5; i++) th[i] = 1'b0;
                  for (int i = 0; i < 3; i++) begin sh[i] = 1'b0; bh[i] = 1'b0; end
                  nsamp   = 0;
                  lvl     = 1'b0;
                  run     = 0;
                  step_p  = 1'b0;
                  m_state = M_PAUSE;
                  m_cnt   = 0;
                  q.delete();
               end else begin
                  cyc++;
                  for (int i = 4; i > 0; i--) th[i] = th[i-1];
                  for (int i = 2; i > 0; i--) begin sh[i] = sh[i-1]; bh[i] = bh[i-1]; end
                  th[0] = tick_in;
                  sh[0] = sw_auto;
                  bh[0] = btn_step;
                  if (nsamp < 10) nsamp++;
                  // rising edge between two real samples, 3 edges after first high sample
                  tick_ev = th[3] && !th[4] && (nsamp >= 5);
                  step    = step_p;
                  step_p  = 1'b0;
                  if (bh[2] != lvl) begin
                     run++;
                     if (run == DB) begin
                        lvl    = bh[2];
                        run    = 0;
                        step_p = lvl;
                     end
                  end else begin
                     run = 0;
                  end
                  en = 1'b0;
                  if (m_state != M_HALT) begin
                     if (halt) m_state = M_HALT;
                     else if (m_state == M_PAUSE) begin
                        if (sh[2]) m_state = M_RUN;
                        else if (step) en = 1'b1;
                     end else begin
                        if (!sh[2]) m_state = M_PAUSE;
                        else if (tick_ev) en = 1'b1;
                     end
                  end
                  if (en) begin
                     m_cnt = (m_cnt + 1) % (1 << CW);
                     q.push_back('{cyc, m_cnt});
                  end
               end
            end
         end
         // Monitor: compare DUT pulses against predictions.
         begin : monitor
            exp_t e;
            bit   prev_en;
            prev_en = 1'b0;
            forever begin
               @(negedge clk);
               if (rst) begin
                  prev_en = 1'b0;
               end else begin
                  chk("running", int'(running), int'(m_state == M_RUN));
                  chk("halted", int'(halted), int'(m_state == M_HALT));
                  if (cpu_en) begin
                     chk("cpu_en_back_to_back", int'(prev_en), 0);
                     if (q.size() == 0) begin
                        chk("unexpected_cpu_en", 1, 0);
                     end else begin
                        e = q.pop_front();
                        chk("pulse_cycle", cyc, e.cyc);
                        chk("pulse_cnt", int'(cycle_cnt), e.cnt);
                     end
                  end
                  while (q.size() > 0 && q[0].cyc <= cyc) begin
                     e = q.pop_front();
                     chk("missed_cpu_en_at_cycle", 0, e.cyc);
                  end
                  prev_en = cpu_en;
               end
            end
         end
      join_none

      // Reset state, with button and tick held high through release
      btn_step = 1'b1;
      tick_in  = 1'b1;
      cycles(3);
      #1;
      chk("rst_cpu_en", int'(cpu_en), 0);
      chk("rst_running", int'(running), 0);
      chk("rst_halted", int'(halted), 0);
      chk("rst_cycle_cnt", int'(cycle_cnt), 0);
      @(negedge clk);
      rst = 1'b0;
      cycles(15);
      chk("held_btn_one_step", int'(cycle_cnt), 1);
      btn_step = 1'b0;
      sw_auto  = 1'b1;
      cycles(10);
      chk("tick_high_at_release_ignored", int'(cycle_cnt), 1);
      tick_in = 1'b0;
      cycles(3);
      tick_period(4, 4);
      cycles(4);
      chk("tick_after_release_edge", int'(cycle_cnt), 2);

      // Free-run: 5 tick periods
      do_reset();
      sw_auto = 1'b1;
      cycles(6);
      for (int p = 0; p < 5; p++) tick_period(20, 20);
      cycles(6);
      chk("free_run_5_pulses", int'(cycle_cnt), 5);

      // Manual step with bounce, ticks toggling meanwhile
      do_reset();
      sw_auto = 1'b0;
      cycles(4);
      btn_step = 1'b1; tick_in = 1'b1; cycles(1);
      btn_step = 1'b0; cycles(1);
      btn_step = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i % 3 == 0) tick_in = ~tick_in;
         cycles(1);
      end
      btn_step = 1'b0;
      tick_in  = 1'b0;
      cycles(12);
      chk("bounce_one_step", int'(cycle_cnt), 1);

      // Random mixed traffic
      rand_run(400);
      sw_auto = 1'b0;
      cycles(10);

      // sw_auto 1->0 coincident with a tick rise
      do_reset();
      sw_auto = 1'b1;
      cycles(6);
      tick_period(4, 4);
      cycles(4);
      sw_auto = 1'b0;
      tick_in = 1'b1;
      cycles(8);
      chk("mode_change_wins_cnt", int'(cycle_cnt), 1);
      chk("mode_change_running", int'(running), 0);
      tick_in = 1'b0;
      cycles(4);

      // Wrap: 16 pulses with CNT_W = 4
      do_reset();
      sw_auto = 1'b1;
      cycles(6);
      for (int p = 0; p < 15; p++) tick_period(4, 4);
      cycles(4);
      chk("preload_all_ones", int'(cycle_cnt), 15);
      tick_period(4, 4);
      cycles(4);
      chk("wrap_to_zero", int'(cycle_cnt), 0);

      // Reset mid-pulse with cycle_cnt = 7
      do_reset();
      sw_auto = 1'b1;
      cycles(6);
      for (int p = 0; p < 6; p++) tick_period(4, 4);
      tick_in = 1'b1;
      cycles(3);
      @(posedge clk);
      #2;
      chk("pre_rst_cpu_en", int'(cpu_en), 1);
      chk("pre_rst_cycle_cnt", int'(cycle_cnt), 7);
      rst = 1'b1;
      #1;
      chk("async_rst_cpu_en", int'(cpu_en), 0);
      chk("async_rst_cycle_cnt", int'(cycle_cnt), 0);
      chk("async_rst_running", int'(running), 0);
      chk("async_rst_halted", int'(halted), 0);
      tick_in = 1'b0;
      cycles(2);
      rst = 1'b0;
      cycles(4);

      // Halt coincident with a tick event in RUN
      sw_auto = 1'b1;
      cycles(6);
      tick_in = 1'b1;
      cycles(3);
      halt = 1'b1;
      cycles(1);
      halt = 1'b0;
      cycles(2);
      chk("halt_wins_cnt", int'(cycle_cnt), 0);
      chk("halt_halted", int'(halted), 1);
      tick_in = 1'b0;
      rand_run(150);
      btn_step = 1'b1; cycles(10); btn_step = 1'b0;
      sw_auto = 1'b0; cycles(6); sw_auto = 1'b1; cycles(6);
      chk("halted_sticky", int'(halted), 1);
      chk("halted_no_pulses", int'(cycle_cnt), 0);
      chk("halted_not_running", int'(running), 0);

      cycles(10);
      chk("pending_predictions", q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
